ft_recovery_unit: RTL and testbench

Recovery engine downstream of ft_control in the FT manager, started by its recover pulse.
- Copies the architectural register file of the healthy core into both cores over the regfile debug/recovery ports, then restores the checkpointed PC.
- Returns a one-cycle done pulse that ft_control consumes as recovery_done_i.
- Runs while the cores are held frozen by the FT manager.

---
 rtl/ft_recovery_unit.sv | 113 +++++++++++
 tb/tb_ft_recovery_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ft_recovery_unit.sv
// Recovery engine: copies the healthy core's register file (x1 upward) into both cores,
// then restores the checkpointed PC and pulses recovery_done_o for one cycle.
module ft_recovery_unit #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  recover_i,
    input  logic                  core_sel_i,
    input  logic [DATA_WIDTH-1:0] pc_checkpoint_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  pc_we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  recovery_done_o
);

    typedef enum logic [2:0] {IDLE, COPY, DRAIN, PC, DONE} state_t;

    // One extra pointer bit keeps the terminal compare exact when NUM_REGS == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(NUM_REGS - 1);

    state_t                state_reg;
    logic                  sel_reg;
    logic [DATA_WIDTH-1:0] pc_ckpt_reg;
    logic [ADDR_WIDTH:0]   rd_ptr_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic                  pc_we_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic                  busy_reg;
    logic                  done_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            sel_reg     <= 1'b0;
            pc_ckpt_reg <= '0;
            rd_ptr_reg  <= '0;
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            pc_we_reg   <= 1'b0;
            pc_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            pc_we_reg <= 1'b0;
            pc_reg    <= '0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (recover_i) begin
                        sel_reg     <= core_sel_i;
                        pc_ckpt_reg <= pc_checkpoint_i;
                        rd_ptr_reg  <= (ADDR_WIDTH+1)'(1);
                        busy_reg    <= 1'b1;
                        state_reg   <= COPY;
                    end
                end
                COPY: begin
                    // The address issued this cycle is written next cycle, when its data returns.
                    we_reg    <= 1'b1;
                    waddr_reg <= rd_ptr_reg[ADDR_WIDTH-1:0];
                    if (rd_ptr_reg == LAST_ADDR) begin
                        rd_ptr_reg <= '0;
                        state_reg  <= DRAIN;
                    end else begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    pc_we_reg <= 1'b1;
                    pc_reg    <= pc_ckpt_reg;
                    state_reg <= PC;
                end
                PC: begin
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    rd_ptr_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rf_raddr_o      = rd_ptr_reg[ADDR_WIDTH-1:0];
    assign rf_we_o         = we_reg;
    assign rf_waddr_o      = waddr_reg;
    // Read data arrives registered from the core one cycle after the address, so the
    // write data is steered straight through, gated by the registered strobe.
    assign rf_wdata_o      = we_reg ? (sel_reg ? rf_rdata_b_i : rf_rdata_a_i) : '0;
    assign pc_we_o         = pc_we_reg;
    assign pc_o            = pc_reg;
    assign busy_o          = busy_reg;
    assign recovery_done_o = done_reg;

endmodule

// File: tb/tb_ft_recovery_unit.sv
// Directed bench for ft_recovery_unit with two behavioural core register files
// (registered read, write on strobe) attached to the recovery ports.
module tb_ft_recovery_unit;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          recover_i = 1'b0;
    logic          core_sel_i = 1'b0;
    logic [DW-1:0] pc_checkpoint_i = '0;
    logic [AW-1:0] rf_raddr_o;
    logic [DW-1:0] rf_rdata_a_i;
    logic [DW-1:0] rf_rdata_b_i;
    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          pc_we_o;
    logic [DW-1:0] pc_o;
    logic          busy_o;
    logic          recovery_done_o;

    ft_recovery_unit #(.NUM_REGS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .recover_i(recover_i), .core_sel_i(core_sel_i),
        .pc_checkpoint_i(pc_checkpoint_i), .rf_raddr_o(rf_raddr_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .pc_we_o(pc_we_o), .pc_o(pc_o),
        .busy_o(busy_o), .recovery_done_o(recovery_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Core register file models.
    logic [DW-1:0] rf_a [N];
    logic [DW-1:0] rf_b [N];
    logic          preload_req = 1'b0;

    always @(posedge clk_i) begin
        if (preload_req) begin
            for (int k = 0; k < N; k++) begin
                rf_a[k] <= 32'hA000_0000 + k;
                rf_b[k] <= 32'hB000_0000 + k;
            end
        end else if (rf_we_o) begin
            rf_a[rf_waddr_o] <= rf_wdata_o;
            rf_b[rf_waddr_o] <= rf_wdata_o;
        end
        rf_rdata_a_i <= rf_a[rf_raddr_o];
        rf_rdata_b_i <= rf_b[rf_raddr_o];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          sel;
        logic [DW-1:0] pc;
        int            hold;
        bit            repulse;
        bit            toggle;
        logic [DW-1:0] exp_base;
    } vec_t;

    vec_t vecs [5];

    // Preload both files, then raise recover_i so that it is sampled at edge 0.
    task automatic start_seq(input logic sel, input logic [DW-1:0] pc);
        @(negedge clk_i);
        preload_req = 1'b1;
        @(negedge clk_i);
        preload_req     = 1'b0;
        recover_i       = 1'b1;
        core_sel_i      = sel;
        pc_checkpoint_i = pc;
        @(posedge clk_i);
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        logic [DW-1:0] e_raddr, e_waddr, e_wdata, e_pc;
        logic          e_we, e_pcwe, e_busy, e_done;
        start_seq(v.sel, v.pc);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            e_busy  = (c <= N + 2);
            e_raddr = (c <= N - 1) ? DW'(c) : '0;
            e_we    = (c >= 2) && (c <= N);
            e_waddr = e_we ? DW'(c - 1) : '0;
            e_wdata = e_we ? v.exp_base + DW'(c - 1) : '0;
            e_pcwe  = (c == N + 1);
            e_pc    = e_pcwe ? v.pc : '0;
            e_done  = (c == N + 2);
            check($sformatf("v%0d c%0d busy", vi, c), DW'(busy_o), DW'(e_busy));
            check($sformatf("v%0d c%0d raddr", vi, c), DW'(rf_raddr_o), e_raddr);
            check($sformatf("v%0d c%0d we", vi, c), DW'(rf_we_o), DW'(e_we));
            check($sformatf("v%0d c%0d waddr", vi, c), DW'(rf_waddr_o), e_waddr);
            check($sformatf("v%0d c%0d wdata", vi, c), rf_wdata_o, e_wdata);
            check($sformatf("v%0d c%0d pc_we", vi, c), DW'(pc_we_o), DW'(e_pcwe));
            check($sformatf("v%0d c%0d pc", vi, c), pc_o, e_pc);
            check($sformatf("v%0d c%0d done", vi, c), DW'(recovery_done_o), DW'(e_done));
            recover_i = (c < v.hold) || (v.repulse && (c == 10 || c == 20));
            if (v.toggle && c == 5) begin
                core_sel_i      = ~v.sel;
                pc_checkpoint_i = 32'hFFFF_FFF0;
            end
        end
        for (int k = 1; k < N; k++) begin
            check($sformatf("v%0d rf_a x%0d", vi, k), rf_a[k], v.exp_base + DW'(k));
            check($sformatf("v%0d rf_b x%0d", vi, k), rf_b[k], v.exp_base + DW'(k));
        end
        check($sformatf("v%0d rf_a x0", vi), rf_a[0], 32'hA000_0000);
        check($sformatf("v%0d rf_b x0", vi), rf_b[0], 32'hB000_0000);
        $display("vector %0d sel=%0d pc=%h hold=%0d repulse=%0d toggle=%0d done", vi, v.sel,
                 v.pc, v.hold, v.repulse, v.toggle);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{sel: 1'b0, pc: 32'h0000_0200, hold: 1, repulse: 1'b0, toggle: 1'b0, exp_base: 32'hA000_0000};
        vecs[1] = '{sel: 1'b1, pc: 32'h0000_0200, hold: 1, repulse: 1'b0, toggle: 1'b1, exp_base: 32'hB000_0000};
        vecs[2] = '{sel: 1'b0, pc: 32'h0000_1234, hold: 1, repulse: 1'b1, toggle: 1'b0, exp_base: 32'hA000_0000};
        vecs[3] = '{sel: 1'b1, pc: 32'hDEAD_BEE0, hold: 3, repulse: 1'b0, toggle: 1'b0, exp_base: 32'hB000_0000};
        vecs[4] = '{sel: 1'b0, pc: 32'h0000_0000, hold: 1, repulse: 1'b0, toggle: 1'b1, exp_base: 32'hA000_0000};

        // Reset state
        #12;
        check("rst busy", DW'(busy_o), '0);
        check("rst we", DW'(rf_we_o), '0);
        check("rst raddr", DW'(rf_raddr_o), '0);
        check("rst pc_we", DW'(pc_we_o), '0);
        check("rst pc", pc_o, '0);
        check("rst done", DW'(recovery_done_o), '0);
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a copy: strobes drop at once, no done, partial copy kept.
        start_seq(1'b1, 32'h0000_0400);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_i);
            recover_i = 1'b0;
        end
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst we", DW'(rf_we_o), '0);
        check("midrst busy", DW'(busy_o), '0);
        check("midrst pc_we", DW'(pc_we_o), '0);
        check("midrst wdata", rf_wdata_o, '0);
        check("midrst raddr", DW'(rf_raddr_o), '0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (recovery_done_o) cnt++;
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (recovery_done_o || busy_o) cnt++;
        end
        check("midrst no done/busy", DW'(cnt), '0);
        check("midrst x14 copied", rf_a[14], 32'hB000_000E);
        check("midrst x15 untouched", rf_a[15], 32'hA000_000F);
        $display("reset mid-sequence done");
        run_vec(5, vecs[0]);

        // Back-to-back: recover_i high in the IDLE cycle right after DONE.
        start_seq(1'b0, 32'h0000_0800);
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk_i);
            if (c == N + 2) check("b2b first done", DW'(recovery_done_o), 1);
            recover_i = (c == N + 3);
        end
        @(negedge clk_i);
        recover_i = 1'b0;
        check("b2b busy", DW'(busy_o), 1);
        check("b2b raddr", DW'(rf_raddr_o), 1);
        cnt = N + 4;
        while (!recovery_done_o && cnt < N + 60) begin
            @(negedge clk_i);
            cnt++;
        end
        check("b2b second done cycle", DW'(cnt), DW'(2 * N + 5));
        $display("back-to-back sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
